// File: rtl/low_freq_fir.sv
// Low-band FIR stage: multiply-accumulates one swept window of queue samples against
// ROM coefficients and emits one saturated 16-bit result per completed sweep.
module low_freq_fir #(
  parameter int NUM_TAPS = 1021,
  parameter int ACC_W    = 42,
  parameter int ADDR_W   = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sequencing,
  input  logic signed [15:0]       smpl_in,
  input  logic signed [15:0]       coeff,
  output logic        [ADDR_W-1:0] coeff_addr,
  output logic signed [15:0]       filt_out,
  output logic                     filt_vld,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);

  state_t                    state;
  logic signed [ACC_W-1:0]   acc;
  logic        [ADDR_W-1:0]  tap_cnt;
  logic signed [31:0]        prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   shifted;
  logic        [ACC_W-16:0]  upper;
  logic signed [15:0]        sat;

  assign prod     = smpl_in * coeff;
  assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};
  assign shifted  = acc >>> 15;
  assign upper    = shifted[ACC_W-1:15];

  // The result fits in 16 bits only when every bit from bit 15 upward agrees with the sign.
  always_comb begin
    sat = shifted[15:0];
    if (!((&upper) || (~|upper)))
      sat = upper[ACC_W-16] ? 16'sh8000 : 16'sh7FFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      coeff_addr <= '0;
      filt_out   <= '0;
      filt_vld   <= 1'b0;
      busy       <= 1'b0;
      acc        <= '0;
      tap_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          filt_vld   <= 1'b0;
          coeff_addr <= '0;
          if (sequencing) begin
            acc        <= '0;
            tap_cnt    <= '0;
            coeff_addr <= ADDR_W'(1);
            busy       <= 1'b1;
            state      <= MAC;
          end
        end
        MAC: begin
          filt_vld <= 1'b0;
          if (!sequencing) begin
            acc        <= '0;
            tap_cnt    <= '0;
            coeff_addr <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            acc <= acc + prod_ext;
            // Hold address and count on the last tap so neither runs past the window.
            if (tap_cnt == LAST_TAP) begin
              state <= DONE;
            end else begin
              tap_cnt    <= tap_cnt + ADDR_W'(1);
              coeff_addr <= coeff_addr + ADDR_W'(1);
            end
          end
        end
        DONE: begin
          filt_out   <= sat;
          filt_vld   <= 1'b1;
          coeff_addr <= '0;
          tap_cnt    <= '0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          filt_vld   <= 1'b0;
          coeff_addr <= '0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_low_freq_fir.sv
// Directed bench for low_freq_fir with a registered coefficient ROM model and
// hand-computed expected results.
module tb_low_freq_fir;

  localparam int NUM_TAPS = 1021;
  localparam int ADDR_W   = 10;
  localparam int PERIOD   = NUM_TAPS + 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     sequencing;
  logic signed [15:0]       smpl_in;
  logic signed [15:0]       coeff;
  logic        [ADDR_W-1:0] coeff_addr;
  logic signed [15:0]       filt_out;
  logic                     filt_vld;
  logic                     busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] rom     [0:1023];
  logic [15:0] samples [0:1023];

  always #5 clk = ~clk;

  // Coefficient ROM with one cycle of read latency.
  always @(posedge clk) coeff <= rom[coeff_addr];

  low_freq_fir #(.NUM_TAPS(NUM_TAPS), .ACC_W(42), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .sequencing(sequencing), .smpl_in(smpl_in), .coeff(coeff),
    .coeff_addr(coeff_addr), .filt_out(filt_out), .filt_vld(filt_vld), .busy(busy)
  );

  task automatic set_rom_const(input logic [15:0] v);
    for (int i = 0; i < 1024; i++) rom[i] = (i < NUM_TAPS) ? v : 16'h0000;
  endtask

  task automatic set_samples_const(input logic [15:0] v);
    for (int i = 0; i < 1024; i++) samples[i] = v;
  endtask

  // Raise sequencing in IDLE (cycle t0), then present samples[k] in cycle t0+1+k.
  task automatic drive_taps(input int n, output int addr_err, output int vld_cnt);
    addr_err = 0;
    vld_cnt  = 0;
    @(negedge clk);
    sequencing = 1'b1;
    smpl_in    = samples[0];
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      smpl_in = samples[k];
      if (coeff_addr !== ADDR_W'(k + 1)) addr_err++;
      if (filt_vld !== 1'b0) vld_cnt++;
    end
  endtask

  // Observe the DONE cycle, the result cycle and the cycle after it.
  task automatic finish_sweep(output logic d_busy, output logic d_vld, output logic [ADDR_W-1:0] d_addr,
                              output logic r_vld, output logic r_busy, output logic [15:0] r_out,
                              output logic [ADDR_W-1:0] r_addr, output logic a_vld);
    @(negedge clk);
    d_busy = busy; d_vld = filt_vld; d_addr = coeff_addr;
    sequencing = 1'b0;
    smpl_in    = 'x;
    @(negedge clk);
    r_vld = filt_vld; r_busy = busy; r_out = filt_out; r_addr = coeff_addr;
    @(negedge clk);
    a_vld = filt_vld;
  endtask

  task automatic test_reset();
    rst = 1'b1; sequencing = 1'b0; smpl_in = 'x;
    repeat (3) @(negedge clk);
    total++; if (coeff_addr !== 10'd0) begin bad++; $display("[TB] FAIL reset_addr got=%0d exp=0", coeff_addr); end
    total++; if (filt_out !== 16'h0000) begin bad++; $display("[TB] FAIL reset_out got=%h exp=0000", filt_out); end
    total++; if (filt_vld !== 1'b0) begin bad++; $display("[TB] FAIL reset_vld got=%b exp=0", filt_vld); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single_tap();
    int ae, vc; logic db, dv, rv, rb, av; logic [15:0] ro; logic [ADDR_W-1:0] da, ra;
    set_rom_const(16'h0000); rom[0] = 16'h4000;
    set_samples_const(16'h1000);
    drive_taps(NUM_TAPS, ae, vc);
    finish_sweep(db, dv, da, rv, rb, ro, ra, av);
    total++; if (vc != 0) begin bad++; $display("[TB] FAIL single_early_vld got=%0d exp=0", vc); end
    total++; if (db !== 1'b1 || dv !== 1'b0) begin bad++; $display("[TB] FAIL single_done busy/vld got=%b%b exp=10", db, dv); end
    total++; if (rv !== 1'b1) begin bad++; $display("[TB] FAIL single_vld got=%b exp=1", rv); end
    total++; if (ro !== 16'h0800) begin bad++; $display("[TB] FAIL single_out got=%h exp=0800", ro); end
    total++; if (rb !== 1'b0) begin bad++; $display("[TB] FAIL single_busy got=%b exp=0", rb); end
    total++; if (av !== 1'b0) begin bad++; $display("[TB] FAIL single_vld_width got=%b exp=0", av); end
  endtask

  task automatic test_saturation();
    int ae, vc; logic db, dv, rv, rb, av; logic [15:0] ro; logic [ADDR_W-1:0] da, ra;
    set_rom_const(16'h7FFF);
    set_samples_const(16'h7FFF);
    drive_taps(NUM_TAPS, ae, vc);
    finish_sweep(db, dv, da, rv, rb, ro, ra, av);
    total++; if (rv !== 1'b1 || ro !== 16'h7FFF) begin bad++; $display("[TB] FAIL sat_pos vld/out got=%b/%h exp=1/7fff", rv, ro); end
    set_samples_const(16'h8000);
    drive_taps(NUM_TAPS, ae, vc);
    finish_sweep(db, dv, da, rv, rb, ro, ra, av);
    total++; if (rv !== 1'b1 || ro !== 16'h8000) begin bad++; $display("[TB] FAIL sat_neg vld/out got=%b/%h exp=1/8000", rv, ro); end
  endtask

  task automatic test_impulse();
    int ae, vc; logic db, dv, rv, rb, av; logic [15:0] ro; logic [ADDR_W-1:0] da, ra;
    for (int i = 0; i < 1024; i++) rom[i] = (i < NUM_TAPS) ? 16'(i) : 16'h0000;
    set_samples_const(16'h0000); samples[5] = 16'h7FFF;
    drive_taps(NUM_TAPS, ae, vc);
    finish_sweep(db, dv, da, rv, rb, ro, ra, av);
    total++; if (ae != 0) begin bad++; $display("[TB] FAIL impulse_addr_seq errors got=%0d exp=0", ae); end
    total++; if (da !== 10'd1021) begin bad++; $display("[TB] FAIL impulse_done_addr got=%0d exp=1021", da); end
    total++; if (ra !== 10'd0) begin bad++; $display("[TB] FAIL impulse_idle_addr got=%0d exp=0", ra); end
    total++; if (rv !== 1'b1 || ro !== 16'h0004) begin bad++; $display("[TB] FAIL impulse_out vld/out got=%b/%h exp=1/0004", rv, ro); end
  endtask

  task automatic test_back_to_back();
    int npulse = 0, first = -1, prev = 0, gap_err = 0, val_err = 0;
    set_rom_const(16'h0010);
    @(negedge clk);
    sequencing = 1'b1; smpl_in = 16'h0100;
    for (int c = 1; c <= 3 * PERIOD; c++) begin
      @(negedge clk);
      if (filt_vld === 1'b1) begin
        if (npulse == 0) first = c;
        else if (c - prev != PERIOD) gap_err++;
        if (filt_out !== 16'h007F) val_err++;
        prev = c;
        npulse++;
      end
    end
    sequencing = 1'b0; smpl_in = 'x;
    @(negedge clk);
    total++; if (npulse != 3) begin bad++; $display("[TB] FAIL b2b_pulses got=%0d exp=3", npulse); end
    total++; if (first != PERIOD) begin bad++; $display("[TB] FAIL b2b_first got=%0d exp=%0d", first, PERIOD); end
    total++; if (gap_err != 0) begin bad++; $display("[TB] FAIL b2b_spacing errors got=%0d exp=0", gap_err); end
    total++; if (val_err != 0) begin bad++; $display("[TB] FAIL b2b_values errors got=%0d exp=0", val_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_end_busy got=%b exp=0", busy); end
  endtask

  task automatic test_abort();
    int ae, vc, late_vld = 0; logic db, dv, rv, rb, av; logic [15:0] ro; logic [ADDR_W-1:0] da, ra;
    set_rom_const(16'h0010);
    set_samples_const(16'h0100);
    drive_taps(500, ae, vc);
    @(negedge clk);
    sequencing = 1'b0; smpl_in = 'x;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy got=%b exp=0", busy); end
    total++; if (coeff_addr !== 10'd0) begin bad++; $display("[TB] FAIL abort_addr got=%0d exp=0", coeff_addr); end
    for (int i = 0; i < 6; i++) begin
      if (filt_vld !== 1'b0) late_vld++;
      @(negedge clk);
    end
    total++; if (late_vld != 0) begin bad++; $display("[TB] FAIL abort_vld got=%0d exp=0", late_vld); end
    total++; if (filt_out !== 16'h007F) begin bad++; $display("[TB] FAIL abort_hold got=%h exp=007f", filt_out); end
    set_samples_const(16'h0200);
    drive_taps(NUM_TAPS, ae, vc);
    finish_sweep(db, dv, da, rv, rb, ro, ra, av);
    total++; if (rv !== 1'b1 || ro !== 16'h00FF) begin bad++; $display("[TB] FAIL abort_next vld/out got=%b/%h exp=1/00ff", rv, ro); end
  endtask

  task automatic test_reset_mid();
    int ae, vc, first = -1;
    logic [15:0] out_at = 16'h0000;
    set_rom_const(16'h0010);
    set_samples_const(16'h0100);
    drive_taps(300, ae, vc);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (coeff_addr !== 10'd0 || filt_out !== 16'h0000) begin bad++; $display("[TB] FAIL midrst_addr/out got=%0d/%h exp=0/0000", coeff_addr, filt_out); end
    total++; if (filt_vld !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_vld/busy got=%b/%b exp=0/0", filt_vld, busy); end
    rst = 1'b0;
    for (int c = 1; c <= PERIOD + 2; c++) begin
      @(negedge clk);
      if (filt_vld === 1'b1 && first < 0) begin first = c; out_at = filt_out; end
    end
    sequencing = 1'b0; smpl_in = 'x;
    total++; if (first != PERIOD) begin bad++; $display("[TB] FAIL midrst_restart got=%0d exp=%0d", first, PERIOD); end
    total++; if (out_at !== 16'h007F) begin bad++; $display("[TB] FAIL midrst_out got=%h exp=007f", out_at); end
  endtask

  initial begin
    rst = 1'b1; sequencing = 1'b0; smpl_in = 'x;
    set_rom_const(16'h0000);
    set_samples_const(16'h0000);
    test_reset();
    test_single_tap();
    test_saturation();
    test_impulse();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
